pr_irq_ctrl: RTL and testbench

Peripheral interrupt controller between the device IRQ lines (Timer, MiniUART, Switch, Key) and the CPU's `Pr_IP[15:10]` input. It latches interrupt requests as per-source pending bits, applies a software mask and trigger mode, and drives `Pr_IP`. It also exposes a small register file on the Bridge peripheral bus, so the exception handler can identify and clear sources. It occupies one chip-select slot behind the Bridge and replaces the direct IRQ-to-`Pr_IP` wiring.

---
 rtl/pr_irq_pkg.sv | 19 +
 rtl/irq_edge_det.sv | 25 ++
 rtl/pr_irq_ctrl.sv | 95 +++++++++
 tb/tb_pr_irq_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pr_irq_pkg.sv
// Shared definitions for the peripheral interrupt controller.
package pr_irq_pkg;

  typedef enum logic [1:0] {
    OFF_PEND = 2'd0,
    OFF_MASK = 2'd1,
    OFF_MODE = 2'd2,
    OFF_ENC  = 2'd3
  } reg_off_e;

  localparam int unsigned SRC_TIMER  = 0;
  localparam int unsigned SRC_UART   = 1;
  localparam int unsigned SRC_SWITCH = 2;
  localparam int unsigned SRC_KEY    = 3;

  // Bit of the CPU's Pr_IP field that source 0 drives.
  localparam int unsigned PR_IP_BASE = 10;

endpackage

// File: rtl/irq_edge_det.sv
// Per-source pending bit: rising-edge latch with W1C, or level follower.
module irq_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic mode,
  input  logic w1c,
  input  logic irq,
  output logic pend
);

  logic prev;

  // prev always tracks the input so a mode switch never fakes an edge; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= irq;
      if (mode) pend <= (irq & ~prev) | (pend & ~w1c);
      else      pend <= irq;
    end
  end

endmodule

// File: rtl/pr_irq_ctrl.sv
// Peripheral interrupt controller: pending/mask/mode registers on the Bridge bus, drives Pr_IP[15:10].
module pr_irq_ctrl
  import pr_irq_pkg::*;
#(
  parameter int unsigned       N_SRC    = 4,
  parameter logic [N_SRC-1:0]  MASK_RST = '0,
  parameter logic [N_SRC-1:0]  MODE_RST = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             We,
  input  logic [1:0]       ADDR,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  input  logic [N_SRC-1:0] irq_in,
  output logic [5:0]       Pr_IP,
  output logic             irq_any
);

  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] masked_pend;
  logic             wr;
  logic             enc_any;
  logic [2:0]       enc_idx;
  logic             unused_wd;

  assign wr        = sel & We;
  assign unused_wd = &{1'b0, WD[31:N_SRC]};

  // W1C strobes for the pending bits, only on a selected write to PEND.
  always_comb begin
    w1c = '0;
    if (wr && (ADDR == OFF_PEND)) w1c = WD[N_SRC-1:0];
  end

  // MASK and MODE software registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= MASK_RST;
      mode_q <= MODE_RST;
    end else if (wr) begin
      if (ADDR == OFF_MASK) mask_q <= WD[N_SRC-1:0];
      if (ADDR == OFF_MODE) mode_q <= WD[N_SRC-1:0];
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_edge_det u_det (
      .clk   (clk),
      .reset (reset),
      .mode  (mode_q[g]),
      .w1c   (w1c[g]),
      .irq   (irq_in[g]),
      .pend  (pend[g])
    );
  end

  assign masked_pend = pend & mask_q;

  // Priority encoder: scanning from the top down leaves the lowest-numbered source.
  always_comb begin
    enc_any = |masked_pend;
    enc_idx = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (masked_pend[i-1]) enc_idx = 3'(i - 1);
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    RD = '0;
    case (reg_off_e'(ADDR))
      OFF_PEND: RD[N_SRC-1:0] = pend;
      OFF_MASK: RD[N_SRC-1:0] = mask_q;
      OFF_MODE: RD[N_SRC-1:0] = mode_q;
      OFF_ENC: begin
        RD[31]  = enc_any;
        RD[2:0] = enc_idx;
      end
      default:  RD = '0;
    endcase
  end

  // CPU interrupt lines; bits above N_SRC stay low.
  always_comb begin
    Pr_IP              = '0;
    Pr_IP[N_SRC-1:0]   = masked_pend;
    irq_any            = |Pr_IP;
  end

endmodule

// File: tb/tb_pr_irq_ctrl.sv
// Directed self-checking bench for pr_irq_ctrl.
module tb_pr_irq_ctrl;
  import pr_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        We;
  logic [1:0]  ADDR;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [3:0]  irq_in;
  logic [5:0]  Pr_IP;
  logic        irq_any;

  int n_checks = 0;
  int n_errors = 0;

  pr_irq_ctrl #(.N_SRC(4), .MASK_RST(4'b0000), .MODE_RST(4'b1111)) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .We      (We),
    .ADDR    (ADDR),
    .WD      (WD),
    .RD      (RD),
    .irq_in  (irq_in),
    .Pr_IP   (Pr_IP),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; We = 1'b1; ADDR = a; WD = d;
    @(negedge clk);
    sel = 1'b0; We = 1'b0; WD = '0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    ADDR = a;
    #1;
    check(tag, RD, exp);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; We = 1'b0; ADDR = '0; WD = '0; irq_in = '0;

    // Reset defaults
    #2;
    read_check("rst_pend", OFF_PEND, 32'h0);
    read_check("rst_mask", OFF_MASK, 32'h0);
    read_check("rst_mode", OFF_MODE, 32'hF);
    read_check("rst_enc",  OFF_ENC,  32'h0);
    check("rst_pr_ip", {26'b0, Pr_IP}, 32'h0);
    check("rst_irq_any", {31'b0, irq_any}, 32'h0);
    @(negedge clk); reset = 1'b0;

    // Edge latch and clear
    bus_write(OFF_MASK, 32'hF);
    irq_in = 4'b0001;
    @(negedge clk); irq_in = 4'b0000;
    check("edge_set_ip", {26'b0, Pr_IP}, 32'h01);
    @(negedge clk);
    check("edge_hold_ip", {26'b0, Pr_IP}, 32'h01);
    check("edge_irq_any", {31'b0, irq_any}, 32'h1);
    read_check("edge_enc", OFF_ENC, 32'h8000_0000);
    bus_write(OFF_PEND, 32'h1);
    check("edge_clr_ip", {26'b0, Pr_IP}, 32'h0);
    read_check("edge_clr_enc", OFF_ENC, 32'h0);

    // Mask and priority
    bus_write(OFF_MASK, 32'h0);
    irq_in = 4'b1010;
    @(negedge clk); irq_in = 4'b0000;
    read_check("mask_pend", OFF_PEND, 32'hA);
    check("mask_ip_off", {26'b0, Pr_IP}, 32'h0);
    bus_write(OFF_MASK, 32'h8);
    check("mask8_ip", {26'b0, Pr_IP}, 32'h08);
    read_check("mask8_enc", OFF_ENC, 32'h8000_0003);
    bus_write(OFF_MASK, 32'hA);
    check("maskA_ip", {26'b0, Pr_IP}, 32'h0A);
    read_check("maskA_enc", OFF_ENC, 32'h8000_0001);

    // Set/clear collision
    bus_write(OFF_PEND, 32'hF);
    read_check("coll_pre_pend", OFF_PEND, 32'h0);
    @(negedge clk);
    sel = 1'b1; We = 1'b1; ADDR = OFF_PEND; WD = 32'h4; irq_in = 4'b0100;
    @(negedge clk);
    sel = 1'b0; We = 1'b0; WD = '0; irq_in = 4'b0000;
    read_check("coll_pend", OFF_PEND, 32'h4);
    bus_write(OFF_PEND, 32'h4);
    read_check("coll_w1c_pend", OFF_PEND, 32'h0);

    // Level mode with W1C attempted mid-window
    bus_write(OFF_MODE, 32'h0);
    bus_write(OFF_MASK, 32'h2);
    read_check("lvl_mode", OFF_MODE, 32'h0);
    irq_in = 4'b0010;
    for (int unsigned k = 1; k <= 5; k++) begin
      if (k == 3) begin
        sel = 1'b1; We = 1'b1; ADDR = OFF_PEND; WD = 32'h2;
      end else begin
        sel = 1'b0; We = 1'b0; WD = '0;
      end
      @(negedge clk);
      check($sformatf("lvl_ip_c%0d", k), {26'b0, Pr_IP}, 32'h02);
    end
    sel = 1'b0; We = 1'b0; WD = '0;
    irq_in = 4'b0000;
    @(negedge clk);
    check("lvl_fall_ip", {26'b0, Pr_IP}, 32'h0);

    // Async reset mid-operation
    bus_write(OFF_MODE, 32'hF);
    bus_write(OFF_MASK, 32'hF);
    irq_in = 4'b1111;
    @(negedge clk); irq_in = 4'b0000;
    check("ar_pre_ip", {26'b0, Pr_IP}, 32'h0F);
    @(negedge clk);
    irq_in = 4'b0001;
    reset = 1'b1;
    #1;
    check("ar_ip", {26'b0, Pr_IP}, 32'h0);
    check("ar_irq_any", {31'b0, irq_any}, 32'h0);
    read_check("ar_pend", OFF_PEND, 32'h0);
    read_check("ar_mask", OFF_MASK, 32'h0);
    reset = 1'b0;
    read_check("ar_rel_pend", OFF_PEND, 32'h0);
    @(negedge clk);
    read_check("ar_repend", OFF_PEND, 32'h1);

    // Held-high edge input does not re-pend until a 0 is seen
    bus_write(OFF_PEND, 32'h1);
    @(negedge clk);
    read_check("held_no_repend", OFF_PEND, 32'h0);
    irq_in = 4'b0000;
    @(negedge clk); irq_in = 4'b0001;
    @(negedge clk);
    read_check("held_repend", OFF_PEND, 32'h1);
    irq_in = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
